// File: rtl/lc2k_mc_core.sv
// Multicycle LC-2K core: one instruction walks FETCH/DECODE/EXEC[/MEM][/WB].
// Memory port is a simple req/ready handshake shared by fetch and data access.
// Optional build macro LC2K_PERF_CNT_EN adds perf_cycles/perf_retired counters.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | one cycle after reset before the first fetch
// FETCH  | read instruction at PC, latch IR on accept
// DECODE | latch A=R[regA], B=R[regB]
// EXEC   | ALU / address / branch / jump; PC update for beq, jalr, noop, halt
// MEM    | data read (lw) or write (sw); sw retires here on accept
// WB     | register write for add, nor, lw, jalr; PC+1 except jalr
// HALT   | terminal, no memory traffic until reset

module lc2k_mc_core #(
    parameter int ADDR_W = 16,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic [ADDR_W-1:0] dbg_pc
`ifdef LC2K_PERF_CNT_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_retired
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_NOR  = 3'd1;
    localparam logic [2:0] OP_LW   = 3'd2;
    localparam logic [2:0] OP_SW   = 3'd3;
    localparam logic [2:0] OP_BEQ  = 3'd4;
    localparam logic [2:0] OP_JALR = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;
    localparam logic [2:0] OP_NOOP = 3'd7;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [24:0]         r_ir;
    logic [XLEN-1:0]     r_a;
    logic [XLEN-1:0]     r_b;
    logic [XLEN-1:0]     r_res;
    logic [ADDR_W-1:0]   r_maddr;
    logic [XLEN-1:0]     r_regs [8];

    logic [2:0]          w_op;
    logic [2:0]          w_ra;
    logic [2:0]          w_rb;
    logic [2:0]          w_dest;
    logic [XLEN-1:0]     w_off_x;
    logic [XLEN-1:0]     w_eff_sum;
    logic [ADDR_W-1:0]   w_pc_plus1;
    logic [ADDR_W-1:0]   w_br_tgt;
    logic [2:0]          w_wb_idx;

    assign w_op       = r_ir[24:22];
    assign w_ra       = r_ir[21:19];
    assign w_rb       = r_ir[18:16];
    assign w_dest     = r_ir[2:0];
    assign w_off_x    = XLEN'($signed(r_ir[15:0]));
    assign w_eff_sum  = r_a + w_off_x;
    assign w_pc_plus1 = r_pc + ADDR_W'(1);
    assign w_br_tgt   = w_pc_plus1 + w_off_x[ADDR_W-1:0];
    // add/nor write the dest field, lw/jalr write regB
    assign w_wb_idx   = ((w_op == OP_ADD) || (w_op == OP_NOR)) ? w_dest : w_rb;

    assign halted = (r_state == S_HALT);
    assign dbg_pc = r_pc;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and memory port drive (outputs follow registered state only)
    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (r_state)
            S_IDLE: w_state_nxt = S_FETCH;
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = r_pc;
                if (mem_ready) begin
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: w_state_nxt = S_EXEC;
            S_EXEC: begin
                case (w_op)
                    OP_ADD, OP_NOR, OP_JALR: w_state_nxt = S_WB;
                    OP_LW, OP_SW:            w_state_nxt = S_MEM;
                    OP_HALT:                 w_state_nxt = S_HALT;
                    default:                 w_state_nxt = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_addr = r_maddr;
                if (w_op == OP_SW) begin
                    mem_we    = 1'b1;
                    mem_wdata = r_b;
                end
                if (mem_ready) begin
                    w_state_nxt = (w_op == OP_SW) ? S_FETCH : S_WB;
                end
            end
            S_WB:    w_state_nxt = S_FETCH;
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: IR, operand latches, ALU result, PC and register file
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc    <= '0;
            r_ir    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_maddr <= '0;
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ir <= mem_rdata[24:0];
                    end
                end
                S_DECODE: begin
                    r_a <= r_regs[w_ra];
                    r_b <= r_regs[w_rb];
                end
                S_EXEC: begin
                    case (w_op)
                        OP_ADD: r_res <= r_a + r_b;
                        OP_NOR: r_res <= ~(r_a | r_b);
                        OP_LW, OP_SW: r_maddr <= w_eff_sum[ADDR_W-1:0];
                        OP_BEQ: r_pc <= (r_a == r_b) ? w_br_tgt : w_pc_plus1;
                        OP_JALR: begin
                            // link value captured now because PC is overwritten here
                            r_res <= XLEN'(w_pc_plus1);
                            r_pc  <= r_a[ADDR_W-1:0];
                        end
                        default: r_pc <= w_pc_plus1;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (w_op == OP_SW) begin
                            r_pc <= w_pc_plus1;
                        end else begin
                            r_res <= mem_rdata;
                        end
                    end
                end
                S_WB: begin
                    if (w_wb_idx != 3'd0) begin
                        r_regs[w_wb_idx] <= r_res;
                    end
                    if (w_op != OP_JALR) begin
                        r_pc <= w_pc_plus1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef LC2K_PERF_CNT_EN
    logic w_retire;

    assign w_retire = ((r_state == S_EXEC) &&
                       ((w_op == OP_BEQ) || (w_op == OP_NOOP) || (w_op == OP_HALT))) ||
                      (r_state == S_WB) ||
                      ((r_state == S_MEM) && mem_ready && (w_op == OP_SW));

    // Active-cycle and retired-instruction counters, free-running wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cycles  <= '0;
            perf_retired <= '0;
        end else begin
            if ((r_state != S_IDLE) && (r_state != S_HALT)) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
            if (w_retire) begin
                perf_retired <= perf_retired + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lc2k_mc_core.sv
// Directed programs against lc2k_mc_core with a word memory model.
// Expected stores are queued before each program; a monitor pops and compares
// them as the core presents accepted writes.
`timescale 1ns/1ps
module tb_lc2k_mc_core;
    localparam int AW = 8;
    localparam int XL = 32;
    localparam logic [31:0] HALT_I = 32'h0180_0000;
    localparam logic [31:0] NOOP_I = 32'h01C0_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_req, mem_we, mem_ready, halted;
    logic [AW-1:0] mem_addr, dbg_pc;
    logic [XL-1:0] mem_wdata, mem_rdata;
`ifdef LC2K_PERF_CNT_EN
    logic [31:0]   perf_cycles, perf_retired;
`endif

    lc2k_mc_core #(.ADDR_W(AW), .XLEN(XL)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .halted(halted), .dbg_pc(dbg_pc)
`ifdef LC2K_PERF_CNT_EN
        , .perf_cycles(perf_cycles), .perf_retired(perf_retired)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [XL-1:0] data;
    } st_t;

    logic [31:0]   mem [256];
    st_t           exp_q [$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            wait_cfg = 0;
    int            wcnt = 0;
    int            n_writes = 0;
    logic          prev_wait = 1'b0;
    logic [AW-1:0] hold_addr;
    logic [XL-1:0] hold_wdata;
    logic          hold_we;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int op, input int ra, input int rb, input int d);
        return (32'(op) << 22) | (32'(ra) << 19) | (32'(rb) << 16) | 32'(d);
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int ra, input int rb, input int off);
        return (32'(op) << 22) | (32'(ra) << 19) | (32'(rb) << 16) | (32'(off) & 32'h0000_FFFF);
    endfunction

    function automatic st_t mk(input int a, input logic [31:0] d);
        st_t s;
        s.addr = AW'(a);
        s.data = d;
        return s;
    endfunction

    // Memory responder: inputs change 1ns after the rising edge; waits only on writes
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ready || !mem_req) wcnt = 0;
            if (mem_req) begin
                if (mem_we && (wcnt < wait_cfg)) begin
                    mem_ready = 1'b0;
                    wcnt++;
                end else begin
                    mem_ready = 1'b1;
                    mem_rdata = mem[mem_addr];
                end
            end else begin
                mem_ready = 1'b0;
            end
        end
    end

    // Monitor: request stability during waits and scoreboard of accepted stores
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req && prev_wait) begin
                chk("hold_addr", mem_addr, hold_addr);
                chk("hold_we", mem_we, hold_we);
                chk("hold_wdata", mem_wdata, hold_wdata);
            end
            prev_wait  = mem_req && !mem_ready;
            hold_addr  = mem_addr;
            hold_we    = mem_we;
            hold_wdata = mem_wdata;
            if (mem_req && mem_ready && mem_we) begin
                n_writes++;
                mem[mem_addr] = mem_wdata;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL store_unexpected: got addr %0h data %0h expected none", mem_addr, mem_wdata);
                end else begin
                    st_t e;
                    e = exp_q.pop_front();
                    chk("store_addr", mem_addr, e.addr);
                    chk("store_data", mem_wdata, e.data);
                end
            end
        end
    end

    task automatic start_prog();
        @(negedge clk);
        rst_n = 1'b0;
        wait_cfg = 0;
        exp_q.delete();
        for (int i = 0; i < 256; i++) mem[i] = HALT_I;
    endtask

    // Hold reset, check reset outputs, release, check first fetch (cycle 1)
    task automatic release_reset();
        repeat (2) @(negedge clk);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_dbg_pc", dbg_pc, 0);
`ifdef LC2K_PERF_CNT_EN
        chk("rst_perf_cycles", perf_cycles, 0);
        chk("rst_perf_retired", perf_retired, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_fetch_req", mem_req, 1'b1);
        chk("first_fetch_addr", mem_addr, 0);
        chk("first_fetch_we", mem_we, 1'b0);
    endtask

    // n = number of cycles from first FETCH with halted low
    task automatic wait_halt(input int max_cyc, output int n);
        n = 1;
        forever begin
            @(negedge clk);
            if (halted) break;
            n++;
            if (n > max_cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL halt_timeout: got no halt expected halt within %0d cycles", max_cyc);
                break;
            end
        end
        chk("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int wr0;

        // lw then halt: timing and final PC
        start_prog();
        mem[0] = enc_i(2, 0, 1, 5);
        mem[1] = HALT_I;
        mem[5] = 32'd7;
        release_reset();
        wait_halt(200, n);
        chk("p1_cycles", n, 8);
        chk("p1_dbg_pc", dbg_pc, 2);
        repeat (3) @(negedge clk);
        chk("p1_halt_hold", halted, 1'b1);
        chk("p1_halt_no_req", mem_req, 1'b0);

        // ALU, lw, R0 discard, negative sw offset
        start_prog();
        mem[0]  = enc_i(2, 0, 1, 20);
        mem[1]  = enc_i(2, 0, 2, 21);
        mem[2]  = enc_r(0, 1, 2, 3);
        mem[3]  = enc_r(1, 0, 0, 4);
        mem[4]  = enc_i(3, 0, 3, 30);
        mem[5]  = enc_i(3, 0, 4, 31);
        mem[6]  = enc_i(2, 0, 5, 22);
        mem[7]  = enc_i(3, 0, 5, 32);
        mem[8]  = enc_r(0, 1, 1, 0);
        mem[9]  = enc_i(3, 0, 0, 33);
        mem[10] = enc_r(1, 2, 5, 6);
        mem[11] = enc_i(3, 0, 6, 34);
        mem[12] = enc_r(0, 5, 5, 7);
        mem[13] = enc_i(3, 0, 7, 35);
        mem[14] = enc_i(3, 7, 7, -1);
        mem[20] = 32'hFFFF_FFFF;
        mem[21] = 32'd1;
        mem[22] = 32'd7;
        exp_q.push_back(mk(30, 32'h0));
        exp_q.push_back(mk(31, 32'hFFFF_FFFF));
        exp_q.push_back(mk(32, 32'd7));
        exp_q.push_back(mk(33, 32'h0));
        exp_q.push_back(mk(34, 32'hFFFF_FFF8));
        exp_q.push_back(mk(35, 32'd14));
        exp_q.push_back(mk(13, 32'd14));
        release_reset();
        wait_halt(500, n);
        chk("p2_dbg_pc", dbg_pc, 16);

        // beq not taken, taken forward, then self-loop at 6
        start_prog();
        mem[0]  = enc_i(2, 0, 1, 20);
        mem[1]  = enc_i(4, 0, 1, 5);
        mem[2]  = enc_i(4, 1, 1, 2);
        mem[5]  = enc_i(3, 0, 1, 30);
        mem[6]  = enc_i(4, 0, 0, -1);
        mem[20] = 32'd3;
        exp_q.push_back(mk(30, 32'd3));
        release_reset();
        repeat (40) @(negedge clk);
        chk("p3_loop_pc", dbg_pc, 6);
        chk("p3_not_halted", halted, 1'b0);
        chk("p3_queue_empty", exp_q.size(), 0);

        // beq -1 at PC 0 stays at 0
        start_prog();
        mem[0] = enc_i(4, 0, 0, -1);
        release_reset();
        repeat (20) @(negedge clk);
        chk("p3b_self_pc", dbg_pc, 0);
        chk("p3b_not_halted", halted, 1'b0);

        // beq -2 at PC 0 wraps to 0xFF; halt there wraps PC back to 0
        start_prog();
        mem[0] = enc_i(4, 0, 0, -2);
        release_reset();
        repeat (3) @(negedge clk);
        chk("p4_wrap_pc", dbg_pc, 8'hFF);
        wait_halt(200, n);
        chk("p4_halt_pc", dbg_pc, 0);

        // jalr 3 3 at PC 4 with R3=10
        start_prog();
        mem[0]  = enc_i(2, 0, 3, 20);
        mem[1]  = NOOP_I;
        mem[2]  = NOOP_I;
        mem[3]  = NOOP_I;
        mem[4]  = enc_r(5, 3, 3, 0);
        mem[10] = enc_i(3, 0, 3, 30);
        mem[20] = 32'd10;
        exp_q.push_back(mk(30, 32'd5));
        release_reset();
        wait_halt(300, n);
        chk("p5_dbg_pc", dbg_pc, 12);

        // sw with 3 wait cycles: single write, 3 extra cycles
        start_prog();
        mem[0]  = enc_i(2, 0, 1, 20);
        mem[1]  = enc_i(3, 0, 1, 30);
        mem[20] = 32'h1234_5678;
        exp_q.push_back(mk(30, 32'h1234_5678));
        wait_cfg = 3;
        wr0 = n_writes;
        release_reset();
        wait_halt(300, n);
        chk("p6_cycles", n, 15);
        chk("p6_single_write", n_writes - wr0, 1);
        chk("p6_dbg_pc", dbg_pc, 3);

        // same sw, reset asserted in the 2nd wait cycle
        start_prog();
        mem[0]  = enc_i(2, 0, 1, 20);
        mem[1]  = enc_i(3, 0, 1, 30);
        mem[20] = 32'h1234_5678;
        mem[30] = 32'hDEAD_BEEF;
        wait_cfg = 3;
        wr0 = n_writes;
        release_reset();
        n = 0;
        while (!(mem_req && mem_we) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("p7_saw_store_req", mem_req && mem_we, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("p7_abort_req", mem_req, 1'b0);
        chk("p7_abort_pc", dbg_pc, 0);
        chk("p7_abort_halted", halted, 1'b0);
        repeat (4) @(negedge clk);
        chk("p7_no_write", n_writes - wr0, 0);
        chk("p7_mem_kept", mem[30], 32'hDEAD_BEEF);

        // noop, noop, halt: 9 active cycles, 3 retired
        start_prog();
        mem[0] = NOOP_I;
        mem[1] = NOOP_I;
        release_reset();
        wait_halt(200, n);
        chk("p8_cycles", n, 9);
        chk("p8_dbg_pc", dbg_pc, 3);
`ifdef LC2K_PERF_CNT_EN
        repeat (2) @(negedge clk);
        chk("p8_perf_retired", perf_retired, 3);
        chk("p8_perf_cycles", perf_cycles, 9);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/lc2k_mc_core.md
LC2K_MC_CORE -- requirements
Module: lc2k_mc_core

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning PC and memory address width (legal 8..32).
REQ-002 SHALL have parameter XLEN, default 32, meaning register/data width (legal 32..64); instruction fields are always taken from bits [24:0].
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port mem_req  output  1  memory request, held high until accepted.
REQ-006 SHALL have port mem_we  output  1  1 = write (sw), 0 = read (fetch/lw); valid while mem_req is high.
REQ-007 SHALL have port mem_addr  output  ADDR_W  word address; valid while mem_req is high.
REQ-008 SHALL have port mem_wdata  output  XLEN  store data; valid while mem_req and mem_we are high.
REQ-009 SHALL have port mem_rdata  input  XLEN  read data; sampled in the cycle mem_ready is high.
REQ-010 SHALL have port mem_ready  input  1  transfer completes on any edge where mem_req and mem_ready are both high.
REQ-011 SHALL have port halted  output  1  high from the cycle after halt executes until reset.
REQ-012 SHALL have port dbg_pc  output  ADDR_W  current PC.

Function
REQ-013 SHALL be a multicycle FSM with states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-014 SHALL move IDLE->FETCH unconditionally, and FETCH->DECODE on an accepted read that latches mem_rdata[24:0] into IR.
REQ-015 SHALL, in DECODE, latch A=R[IR[21:19]] and B=R[IR[18:16]]; DECODE->EXEC always.
REQ-016 SHALL decode opcode IR[24:22]: 0 add, 1 nor, 2 lw, 3 sw, 4 beq, 5 jalr, 6 halt, 7 noop.
REQ-017 SHALL, in EXEC, compute add A+B and nor ~(A|B) mod 2^XLEN, then go to WB with destination IR[2:0].
REQ-018 SHALL, for lw/sw, form mem_addr = (A + sext(IR[15:0]))[ADDR_W-1:0], then go to MEM.
REQ-019 SHALL, in MEM, hold mem_req until accepted; lw goes to WB writing mem_rdata into R[IR[18:16]]; sw sets mem_we=1, mem_wdata=B and goes to FETCH.
REQ-020 SHALL, for beq, set PC = PC+1+sext(offset) mod 2^ADDR_W if A==B, else PC+1; EXEC->FETCH.
REQ-021 SHALL, for jalr, set PC = A[ADDR_W-1:0] in EXEC and write zero-extended old PC+1 to R[IR[18:16]] in WB; when regA==regB the jump uses the value latched before the write.
REQ-022 SHALL, for noop, set PC = PC+1 and go EXEC->FETCH; for halt, set PC = PC+1 and go EXEC->HALT; HALT SHALL be terminal, with mem_req held at 0.
REQ-023 SHALL set PC = PC+1 (wrapping mod 2^ADDR_W) in WB for add/nor/lw, and in MEM acceptance for sw.
REQ-024 SHALL discard writes to R0 (R0 reads 0 always); R1..R7 are XLEN wide.
REQ-025 SHALL assert mem_req only in FETCH (mem_we=0, mem_addr=PC) and MEM, and SHALL keep addr/we/wdata stable while mem_req is high and mem_ready is low.
REQ-026 SHALL complete the following instructions in the stated number of cycles when there are no wait states: add/nor/jalr 4, lw 5, sw 4, beq/noop/halt 3; each wait cycle adds exactly 1.

Reset
REQ-027 SHALL, while rst_n is sampled low, set state=IDLE, PC=0, R1..R7=0, IR=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, dbg_pc=0.
REQ-028 SHALL abandon a pending memory request if reset occurs mid-transfer; mem_req is low on the edge following the low sample, and no register/PC update occurs.
REQ-029 SHALL issue its first fetch (PC=0) in the second cycle after rst_n is sampled high.

Configuration
REQ-030 SHALL, with LC2K_PERF_CNT_EN defined, add outputs perf_cycles[31:0] and perf_retired[31:0]; both reset to 0, count non-IDLE non-HALT cycles and completed instructions (halt counted) respectively, and wrap at 2^32.
REQ-031 SHALL, without LC2K_PERF_CNT_EN, omit both ports and their counter logic entirely.

Verification
REQ-032 SHALL be verified by: mem[0]=lw 0 1 5, mem[5]=7, mem[1]=halt, zero wait -> R1=7, halted after 8 cycles from first FETCH, dbg_pc=2.
REQ-033 SHALL be verified by: add 1 2 3 with R1=0xFFFFFFFF, R2=1, XLEN=32 -> R3=0; nor 0 0 4 -> R4=0xFFFFFFFF.
REQ-034 SHALL be verified by: beq 0 0 -1 at PC=0 with ADDR_W=8 -> PC=0 (self-loop); beq 0 0 -2 at PC=0 -> PC=0xFF (wrap).
REQ-035 SHALL be verified by: jalr 3 3 with R3=10 at PC=4 -> PC=10, R3=5.
REQ-036 SHALL be verified by: sw with mem_ready low for 3 cycles -> mem_req, mem_addr and mem_wdata held constant, with a single write; rst_n low in the 2nd wait cycle -> mem_req=0 next edge, PC=0.
REQ-037 SHALL be verified by: with LC2K_PERF_CNT_EN defined and a program of noop, noop, halt -> perf_retired=3, perf_cycles=9.
